rgb_scan_controller: RTL and testbench

//  Sequences the 8x8 RGB LED matrix shift-register chain (74HC595-style SH_CP/ST_CP/DS/OE).

---
 rtl/rgb_scan_controller.sv | 212 +++++++++++++++++++++
 tb/tb_rgb_scan_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_scan_controller.sv
// Scan sequencer for an 8x8 RGB LED matrix driven through a 74HC595-style chain.
// Optional feature macro: RGB_DIM_EN adds dim[2:0], which shortens the lit part of each row dwell.
module rgb_scan_controller #(
    parameter int unsigned SHIFT_DIV = 210,
    parameter int unsigned DWELL     = 20000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
`ifdef RGB_DIM_EN
    input  logic [2:0]   dim,
`endif
    input  logic [191:0] frame_data,
    input  logic         frame_valid,
    output logic         frame_ready,
    output logic         SH_CP,
    output logic         ST_CP,
    output logic         DS,
    output logic         OE,
    output logic [2:0]   row_idx,
    output logic         frame_done
);

    localparam int unsigned ROWS    = 8;
    localparam int unsigned PIX_W   = 24;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BIT_W   = $clog2(WORD_W);
    localparam int unsigned ROW_W   = $clog2(ROWS);
    localparam int unsigned CNT_MAX = (DWELL > SHIFT_DIV) ? DWELL : SHIFT_DIV;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef logic [ROWS-1:0][PIX_W-1:0] frame_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_DWELL
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [ROW_W-1:0]    row_q, row_d;
    frame_t              active_q, active_d;
    frame_t              pend_q, pend_d;
    logic                pend_full_q, pend_full_d;
    logic                sh_cp_q, sh_cp_d;
    logic                st_cp_q, st_cp_d;
    logic                ds_q, ds_d;
    logic                oe_q, oe_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;

`ifdef RGB_DIM_EN
    // Lit portion of the dwell: (dim+1)/8 of DWELL, rounded down
    logic [31:0] lit_len_c;
    assign lit_len_c = ((32'(dim) + 32'd1) * DWELL) >> 3;
`endif

    // Next-state, datapath and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        row_d       = row_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        done_d      = 1'b0;
        sh_cp_d     = 1'b0;
        st_cp_d     = 1'b0;
        ds_d        = 1'b0;
        oe_d        = 1'b1;
        ready_d     = ready_q;

        if (frame_valid && !pend_full_q) begin
            pend_d      = frame_data;
            pend_full_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (enable && pend_full_q) begin
                    active_d    = pend_q;
                    pend_full_d = 1'b0;
                    row_d       = '0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shreg_d = {~(ROWS'(1) << row_q), active_q[row_q]};
                cnt_d   = '0;
                phase_d = 1'b0;
                bit_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Each bit: SHIFT_DIV cycles low (data set up), SHIFT_DIV cycles high
                if (cnt_q == CNT_W'(SHIFT_DIV - 1)) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_q == BIT_W'(WORD_W - 1)) begin
                        phase_d = 1'b0;
                        state_d = ST_LATCH;
                    end else begin
                        phase_d = 1'b0;
                        bit_d   = bit_q + BIT_W'(1);
                        shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LATCH: begin
                if (cnt_q == CNT_W'(SHIFT_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DWELL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DWELL: begin
                if (cnt_q == CNT_W'(DWELL - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        done_d = 1'b1;
                        row_d  = '0;
                        // When stopping, the pending frame stays put and is taken by IDLE on restart
                        if (pend_full_q && enable) begin
                            active_d    = pend_q;
                            pend_full_d = 1'b0;
                        end
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                    if (!enable) begin
                        state_d = ST_IDLE;
                        row_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sh_cp_d = (state_d == ST_SHIFT) && phase_d;
        ds_d    = (state_d == ST_SHIFT) && shreg_d[WORD_W-1];
        st_cp_d = (state_d == ST_LATCH);
`ifdef RGB_DIM_EN
        oe_d    = !((state_d == ST_DWELL) && (32'(cnt_d) < lit_len_c));
`else
        oe_d    = (state_d != ST_DWELL);
`endif
        ready_d = !pend_full_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            bit_q       <= '0;
            shreg_q     <= '0;
            row_q       <= '0;
            active_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            sh_cp_q     <= 1'b0;
            st_cp_q     <= 1'b0;
            ds_q        <= 1'b0;
            oe_q        <= 1'b1;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            row_q       <= row_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            sh_cp_q     <= sh_cp_d;
            st_cp_q     <= st_cp_d;
            ds_q        <= ds_d;
            oe_q        <= oe_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign frame_ready = ready_q;
    assign SH_CP       = sh_cp_q;
    assign ST_CP       = st_cp_q;
    assign DS          = ds_q;
    assign OE          = oe_q;
    assign row_idx     = row_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_rgb_scan_controller.sv
// Directed bench for rgb_scan_controller: expected row words are queued when a frame is offered
// and checked against the bits the matrix would latch.
module tb_rgb_scan_controller;

    localparam int unsigned SHIFT_T = 2;
    localparam int unsigned DWELL_T = 16;
    localparam int unsigned ROW_T   = 1 + 64 * SHIFT_T + SHIFT_T + DWELL_T;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [191:0] frame_data;
    logic         frame_valid;
    logic         frame_ready;
    logic         SH_CP, ST_CP, DS, OE;
    logic [2:0]   row_idx;
    logic         frame_done;
`ifdef RGB_DIM_EN
    logic [2:0]   dim = 3'd7;
`endif

    rgb_scan_controller #(.SHIFT_DIV(SHIFT_T), .DWELL(DWELL_T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
`ifdef RGB_DIM_EN
        .dim         (dim),
`endif
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .SH_CP       (SH_CP),
        .ST_CP       (ST_CP),
        .DS          (DS),
        .OE          (OE),
        .row_idx     (row_idx),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [34:0] exp_q[$];
    logic [34:0] exp_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [191:0] f, input int r);
        logic [7:0] sel;
        sel = ~(8'h01 << r);
        return {sel, f[24*r +: 24]};
    endfunction

    task automatic push_frame(input logic [191:0] f);
        for (int r = 0; r < 8; r++) exp_q.push_back({3'(r), exp_word(f, r)});
    endtask

    task automatic wait_done(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
        end
    endtask

    // Matrix-side monitor: reassembles shifted words and checks pin timing
    logic [31:0] sr = '0;
    int unsigned nbits = 0, sh_rises = 0, oe_run = 0, oe_low_total = 0, st_run = 0;
    int unsigned done_cycles = 0, latch_cnt = 0, prev_latch = 0;
    bit          have_prev = 1'b0;
    logic        sh_prev = 1'b0, st_prev = 1'b0, oe_prev = 1'b1, ds_prev = 1'b0;

    always @(negedge clk) begin
        if (SH_CP === 1'b1 && sh_prev === 1'b0) begin
            sr = {sr[30:0], DS};
            nbits++;
            sh_rises++;
        end
        if (rst_n === 1'b1 && DS !== ds_prev) chk("ds_change_while_sh_high", SH_CP, 1'b0);
        if (OE === 1'b0) begin
            oe_run++;
            oe_low_total++;
            chk("oe_low_overlap", {SH_CP, ST_CP}, 2'b00);
        end else if (OE === 1'b1 && oe_prev === 1'b0) begin
            chk("oe_low_len", oe_run, DWELL_T);
            oe_run = 0;
        end
        if (ST_CP === 1'b1) begin
            if (st_prev === 1'b0) begin
                latch_cnt++;
                chk("latch_bits", nbits, 32);
                chk("latch_ds_low", DS, 1'b0);
                total++;
                assert (exp_q.size() > 0) else begin
                    bad++;
                    $error("FAIL latch_unexpected observed=%0h expected=none", sr);
                end
                if (exp_q.size() > 0) begin
                    exp_e = exp_q.pop_front();
                    chk("latch_word", sr, exp_e[31:0]);
                    chk("latch_row", row_idx, exp_e[34:32]);
                end
                if (have_prev && row_idx != 3'd0) chk("row_period", cyc - prev_latch, ROW_T);
                prev_latch = cyc;
                have_prev  = 1'b1;
                nbits      = 0;
            end
            st_run++;
        end else if (st_prev === 1'b1) begin
            chk("st_high_len", st_run, SHIFT_T);
            st_run = 0;
        end
        if (frame_done === 1'b1) done_cycles++;
        if (rst_n === 1'b0) begin
            nbits  = 0;
            sr     = '0;
            oe_run = 0;
            st_run = 0;
        end
        sh_prev = SH_CP;
        st_prev = ST_CP;
        oe_prev = OE;
        ds_prev = DS;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [191:0] fa, fb, fc, fd;
    int unsigned  t_load, snap_sh, snap_oe;
    bit           seen;

    initial begin
        for (int r = 0; r < 8; r++) begin
            fa[24*r +: 24] = {8'(8'h11 * r), 8'(8'h20 + r), 8'(8'hC0 ^ r)};
            fb[24*r +: 24] = {8'(8'h3C ^ r), 8'(5 * r), 8'h81};
            fd[24*r +: 24] = {8'(r), 8'h5A, 8'(9 * r)};
        end
        fa[23:0] = 24'hA500FF;
        fc = ~fb;

        rst_n = 1'b0; enable = 1'b0; frame_valid = 1'b0; frame_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_sh_cp", SH_CP, 1'b0);
        chk("rst_st_cp", ST_CP, 1'b0);
        chk("rst_ds", DS, 1'b0);
        chk("rst_oe", OE, 1'b1);
        chk("rst_row", row_idx, 3'd0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_ready", frame_ready, 1'b1);

        // Frame A, rows scanned from 0
        rst_n = 1'b1;
        frame_data = fa; frame_valid = 1'b1; enable = 1'b1;
        push_frame(fa);
        @(negedge clk);
        frame_valid = 1'b0;
        chk("a_ready_drop", frame_ready, 1'b0);
        @(negedge clk);
        chk("a_ready_after_swap", frame_ready, 1'b1);
        chk("a_load_oe", OE, 1'b1);
        t_load = cyc;

        // Frame B mid row 3; frame C offered while the slot is full
        repeat (3 * ROW_T + 50) @(negedge clk);
        chk("b_row3", row_idx, 3'd3);
        frame_data = fb; frame_valid = 1'b1;
        push_frame(fb);
        @(negedge clk);
        chk("b_ready_drop", frame_ready, 1'b0);
        frame_data = fc;
        repeat (20) @(negedge clk);
        chk("c_ready_hold", frame_ready, 1'b0);
        frame_valid = 1'b0;

        wait_done(2000, seen);
        chk("done_seen", seen, 1'b1);
        chk("done_latency", cyc - t_load, 8 * ROW_T);
        chk("done_ready_swap", frame_ready, 1'b1);
        chk("done_row_wrap", row_idx, 3'd0);
        @(negedge clk);
        chk("done_width", done_cycles, 1);
        chk("done_low", frame_done, 1'b0);

        // Drop enable during row 5 shift of frame B
        repeat (5 * ROW_T + 30 - 1) @(negedge clk);
        chk("en_row5", row_idx, 3'd5);
        enable = 1'b0;
        repeat (120) @(negedge clk);
        chk("idle_row", row_idx, 3'd0);
        chk("idle_oe", OE, 1'b1);
        chk("idle_latches", latch_cnt, 14);
        chk("idle_rows_left", exp_q.size(), 2);
        exp_q.delete();
        snap_sh = sh_rises; snap_oe = oe_low_total;
        repeat (300) @(negedge clk);
        chk("idle_no_sh", sh_rises - snap_sh, 0);
        chk("idle_no_oe", oe_low_total - snap_oe, 0);
        chk("idle_done_count", done_cycles, 1);
        chk("idle_ready", frame_ready, 1'b1);

        // Frame D, reset during bit 10 of row 0
        frame_data = fd; frame_valid = 1'b1; enable = 1'b1;
        push_frame(fd);
        @(negedge clk);
        frame_valid = 1'b0;
        @(negedge clk);
        repeat (42) @(negedge clk);
        chk("d_bit10_pos", nbits, 10);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_sh_cp", SH_CP, 1'b0);
        chk("mid_rst_st_cp", ST_CP, 1'b0);
        chk("mid_rst_ds", DS, 1'b0);
        chk("mid_rst_oe", OE, 1'b1);
        chk("mid_rst_row", row_idx, 3'd0);
        chk("mid_rst_ready", frame_ready, 1'b1);
        chk("mid_rst_unlatched", exp_q.size(), 8);
        exp_q.delete();
        rst_n = 1'b1;
        snap_sh = sh_rises; snap_oe = oe_low_total;
        repeat (200) @(negedge clk);
        chk("post_rst_no_sh", sh_rises - snap_sh, 0);
        chk("post_rst_no_oe", oe_low_total - snap_oe, 0);
        chk("post_rst_ready", frame_ready, 1'b1);
        chk("post_rst_latches", latch_cnt, 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
